ahb_decoder_mux: RTL
====================

# ahb_decoder_mux

Parametrised AHB-Lite decoder and slave-to-master response multiplexer for the AHB interconnect, generalised to `NO_OF_SLAVES` slaves on a contiguous, equal-sized address map. It has a built-in default slave that returns a two-cycle ERROR for unmapped active transfers. It drives `hselx` and `hready` toward the bus and muxes `hrdata`, `hresp`, `hexokay` and `hreadyout` from the slave owning the current data phase. It sits between the master-side bus signals and the slave agents in the hdlTop.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `NO_OF_SLAVES`, 4, mapped slave count (1..16)
- `REGION_BITS`, 16, log2 of region size per slave
- `BASE_REGION`, 0, region index of slave 0; slave i owns region `BASE_REGION+i`
- `hclk`  input  1  bus clock
- `hreset`  input  1  reset; one clock; asynchronous, active-high
- `haddr`  input  ADDR_WIDTH  address-phase address
- `htrans`  input  2  address-phase transfer type
- `hselx`  output  NO_OF_SLAVES  one-hot slave select (address phase)
- `hready`  output  1  bus ready, fed back to master and all slaves
- `hreadyout_s`  input  NO_OF_SLAVES  per-slave ready
- `hresp_s`  input  NO_OF_SLAVES  per-slave response
- `hexokay_s`  input  NO_OF_SLAVES  per-slave exclusive okay
- `hrdata_s`  input  NO_OF_SLAVES*DATA_WIDTH  per-slave read data, slave i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `hrdata`  output  DATA_WIDTH  muxed read data
- `hresp`  output  1  muxed response
- `hexokay`  output  1  muxed exclusive okay
- `decode_err_count`  output  16  saturating count of default-slave ERROR responses

## Operation
- Decode (combinational): region = `haddr[ADDR_WIDTH-1:REGION_BITS]`. If `BASE_REGION <= region < BASE_REGION+NO_OF_SLAVES`, then `hselx[region-BASE_REGION]` = 1; otherwise `hselx` = 0 and the default slave is selected. Decode is independent of `htrans`.
- Data-phase owner register: on a `hclk` edge with `hready`=1, it captures the decoded index (slave or DEFAULT) and `dp_active` = `htrans[1]`. With `hready`=0 it holds.
- Mux: an owner slave i drives `hready`=`hreadyout_s[i]`, `hresp`=`hresp_s[i]`, `hexokay`=`hexokay_s[i]` and `hrdata`=slice i. This applies regardless of `dp_active`, because slaves return OKAY for IDLE/BUSY.
- Owner DEFAULT with `dp_active`=0 gives `hready`=1, `hresp`=0, `hexokay`=0, `hrdata`=0.
- Default-slave FSM has states IDLE, ERR1 and ERR2.
  - IDLE→ERR1: `hready`=1 and the address phase is unmapped with `htrans` NONSEQ/SEQ.
  - ERR1 drives `hready`=0, `hresp`=1 and moves unconditionally to ERR2.
  - ERR2 drives `hready`=1, `hresp`=1. From ERR2 it goes to ERR1 if the current address phase is also unmapped and active, else to IDLE.
  - `hrdata`=0 throughout.
- `decode_err_count` increments by 1 on every entry to ERR1 and saturates at 16'hFFFF.
- Reset values: owner = DEFAULT, `dp_active`=0, FSM=IDLE, `hready`=1, `hresp`=0, `hexokay`=0, `hrdata`=0, `decode_err_count`=0. `hselx` follows `haddr` combinationally.
- Reset mid-transfer aborts the data phase; outputs take reset values asynchronously.

## Timing
- Address-to-`hselx`: 0 cycles (combinational).
- Slave response to bus outputs: 0 cycles (combinational mux on the registered owner).
- Owner switches one edge after the address phase is accepted (`hready`=1).
- Unmapped active transfer: ERROR occupies exactly 2 data-phase cycles (wait + final).
- Back-to-back unmapped transfers: ERR1, ERR2, ERR1, ERR2 with no IDLE gap.
- A wait state (`hreadyout_s`=0) holds the owner and `hselx` decode, and the master must hold `haddr`.

## Structure
- `AhbGlobalPackage` gains the `ahbDefaultSlaveState_e` enum (IDLE/ERR1/ERR2), the `REGION_BITS` and `BASE_REGION` defaults, and a `DEFAULT_IDX` constant (`NO_OF_SLAVES`). It continues to supply `ADDR_WIDTH`, `DATA_WIDTH` and `NO_OF_SLAVES`.
- One sub-module, `ahb_default_slave`, holds the FSM and error counter. The decoder, owner register and mux stay in the top.

## Test plan
- Reset: assert `hreset` during an ERR1 cycle. Required: `hready`=1, `hresp`=0 and `decode_err_count`=0 immediately (asynchronous); the FSM is IDLE after release.
- Decode sweep: `haddr`=32'h0000_0000, 32'h0001_0004, 32'h0003_FFFC and 32'h0004_0000 with NONSEQ. Required `hselx`: 4'b0001, 4'b0010, 4'b1000 and 4'b0000 respectively.
- Read mux: slave 2 is owner and drives `hrdata`=32'hCAFE_F00D with `hreadyout_s[2]` low for 2 cycles. Required: `hready` low 2 cycles, then `hrdata`=32'hCAFE_F00D with `hready`=1.
- Unmapped NONSEQ to 32'h0010_0000. Required: next cycle `hready`=0/`hresp`=1, then `hready`=1/`hresp`=1, then `decode_err_count`=1.
- Unmapped IDLE to 32'h0010_0000. Required: zero-wait OKAY and the counter unchanged. Two back-to-back unmapped NONSEQs give 4 ERROR cycles and a count of 2.
- Counter saturation: preload by 65 535 errors plus one more. Required: the count stays 16'hFFFF.

Source files
------------

// File: rtl/ahb_decoder_mux_pkg.sv
// Shared constants and types for the AHB-Lite decoder / response mux
// and its built-in default slave.
package ahb_decoder_mux_pkg;

    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int NO_OF_SLAVES  = 4;
    localparam int REGION_BITS   = 16;
    localparam int BASE_REGION   = 0;
    localparam int DEFAULT_IDX   = NO_OF_SLAVES;
    localparam int ERR_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ahbDefaultSlaveState_e;

endpackage

// File: rtl/ahb_decoder_mux_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers,
// plus a saturating count of ERROR responses issued.
module ahb_default_slave
    import ahb_decoder_mux_pkg::*;
(
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic                     hready,
    input  logic                     unmapped_active,
    output logic                     ds_hready,
    output logic                     ds_hresp,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    ahbDefaultSlaveState_e    state_q, state_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q   <= DS_IDLE;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            DS_IDLE: if (hready && unmapped_active) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = unmapped_active ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
        // every fresh entry to ERR1 is one ERROR response
        if (state_d == DS_ERR1 && state_q != DS_ERR1 && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end

    // outputs depend on state only, keeping hready free of comb loops
    assign ds_hready = (state_q != DS_ERR1);
    assign ds_hresp  = (state_q != DS_IDLE);
    assign err_count = err_cnt_q;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, data-phase owner register and
// slave-to-master response multiplexer with a default slave.
module ahb_decoder_mux #(
    parameter int ADDR_WIDTH   = ahb_decoder_mux_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = ahb_decoder_mux_pkg::DATA_WIDTH,
    parameter int NO_OF_SLAVES = ahb_decoder_mux_pkg::NO_OF_SLAVES,
    parameter int REGION_BITS  = ahb_decoder_mux_pkg::REGION_BITS,
    parameter int BASE_REGION  = ahb_decoder_mux_pkg::BASE_REGION
) (
    input  logic                             hclk,
    input  logic                             hreset,
    input  logic [ADDR_WIDTH-1:0]            haddr,
    input  logic [1:0]                       htrans,
    output logic [NO_OF_SLAVES-1:0]          hselx,
    output logic                             hready,
    input  logic [NO_OF_SLAVES-1:0]          hreadyout_s,
    input  logic [NO_OF_SLAVES-1:0]          hresp_s,
    input  logic [NO_OF_SLAVES-1:0]          hexokay_s,
    input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] hrdata_s,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             hresp,
    output logic                             hexokay,
    output logic [15:0]                      decode_err_count
);

    localparam int RW    = ADDR_WIDTH - REGION_BITS;
    localparam int IDX_W = $clog2(NO_OF_SLAVES + 1);
    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(NO_OF_SLAVES);
    localparam logic [RW-1:0]    BASE_R  = RW'(BASE_REGION);

    logic [RW-1:0]    region, offset;
    logic [IDX_W-1:0] dec_idx, owner_q, owner_d;
    logic             dp_active_q, dp_active_d;
    logic             unmapped_active;
    logic             ds_hready, ds_hresp;
    logic             unused_addr_lo;

    assign region         = haddr[ADDR_WIDTH-1:REGION_BITS];
    assign offset         = region - BASE_R;
    assign unused_addr_lo = ^haddr[REGION_BITS-1:0];

    always_comb begin
        hselx   = '0;
        dec_idx = DEF_IDX;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (region >= BASE_R && offset == RW'(i)) begin
                hselx[i] = 1'b1;
                dec_idx  = IDX_W'(i);
            end
        end
    end

    assign unmapped_active = (dec_idx == DEF_IDX) && htrans[1];

    always_comb begin
        owner_d     = owner_q;
        dp_active_d = dp_active_q;
        if (hready) begin
            owner_d     = dec_idx;
            dp_active_d = htrans[1];
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            owner_q     <= DEF_IDX;
            dp_active_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            dp_active_q <= dp_active_d;
        end
    end

    // slave owners pass through even for IDLE/BUSY data phases
    always_comb begin
        hready  = 1'b1;
        hresp   = 1'b0;
        hexokay = 1'b0;
        hrdata  = '0;
        if (owner_q == DEF_IDX) begin
            if (dp_active_q) begin
                hready = ds_hready;
                hresp  = ds_hresp;
            end
        end else begin
            for (int i = 0; i < NO_OF_SLAVES; i++) begin
                if (owner_q == IDX_W'(i)) begin
                    hready  = hreadyout_s[i];
                    hresp   = hresp_s[i];
                    hexokay = hexokay_s[i];
                    hrdata  = hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    ahb_default_slave u_def (
        .hclk            (hclk),
        .hreset          (hreset),
        .hready          (hready),
        .unmapped_active (unmapped_active),
        .ds_hready       (ds_hready),
        .ds_hresp        (ds_hresp),
        .err_count       (decode_err_count)
    );

endmodule
